// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared opcode constants, default widths and immediate helpers for the fetch stage
package instr_fetch_pkg;
    localparam int unsigned IF_ADDR_W = 32;
    localparam logic [7:0] OP_B = 8'hA0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] NOP_ALT = 32'hC800_0000;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction
endpackage

// File: rtl/instr_fetch_hold_buf.sv
// fetch_hold_buf: one-entry holding register for an instruction that decode could not take
module fetch_hold_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              capture,
    input  logic              drain,
    input  logic [31:0]       d_instr,
    input  logic [ADDR_W-1:0] d_pc,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);
    // flush beats capture, capture beats drain
    always_ff @(posedge clk) begin
        if (rst || flush) valid <= 1'b0;
        else if (capture) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end else if (drain) valid <= 1'b0;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage with 1-cycle imem, decode handshake, hold buffer and redirect flush
// Optional PREDECODE_BRANCH_EN: unconditional B (opcode A0) redirects the fetch PC on accept.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
    logic [ADDR_W-1:0] pc_q, req_pc_q, hold_pc;
    logic              req_valid_q, hold_valid;
    logic [31:0]       hold_instr;
    logic              issue, capture, drain, take_branch;
    logic [ADDR_W-1:0] branch_pc;

    assign imem_addr = pc_q;

    // output mux, handshake and issue decisions
    always_comb begin
        if_valid    = (hold_valid | req_valid_q) & ~redirect_valid;
        if_instr    = !if_valid ? 32'h0 : hold_valid ? hold_instr : imem_instr;
        if_pc       = !if_valid ? '0 : hold_valid ? hold_pc : req_pc_q;
        capture     = req_valid_q & ~hold_valid & ~if_ready & ~redirect_valid;
        drain       = hold_valid & if_ready;
`ifdef PREDECODE_BRANCH_EN
        take_branch = if_valid & if_ready & (if_instr[31:24] == OP_B);
        branch_pc   = if_pc + ADDR_W'(sext16(if_instr[15:0]));
`else
        take_branch = 1'b0;
        branch_pc   = '0;
`endif
        issue       = ~rst & ~redirect_valid & (~if_valid | if_ready) & ~take_branch;
    end

    // PC and in-flight request; reset, redirect, predecoded branch, then sequential issue
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q        <= redirect_pc;
            req_valid_q <= 1'b0;
        end else if (take_branch) begin
            pc_q        <= branch_pc;
            req_valid_q <= 1'b0;
        end else begin
            req_valid_q <= issue;
            if (issue) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + 1'b1;
            end
        end
    end

    fetch_hold_buf #(.ADDR_W(ADDR_W)) u_hold (
        .clk(clk),
        .rst(rst),
        .flush(redirect_valid),
        .capture(capture),
        .drain(drain),
        .d_instr(imem_instr),
        .d_pc(req_pc_q),
        .valid(hold_valid),
        .instr(hold_instr),
        .pc(hold_pc)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch (honours PREDECODE_BRANCH_EN when defined)
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [63:0] sb[$];
    int          tests = 0;
    int          fails = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h22000005;
            32'd1:   return 32'h24400003;
            32'd2:   return 32'hA8000000;
            32'd3:   return 32'hA000FFFD;
            32'd4:   return 32'hC8000000;
            default: return {8'h55, a[23:0]};
        endcase
    endfunction

    // one-cycle registered instruction memory
    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        rst = r;
        if_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        sb.push_back({pc, mem_word(pc)});
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic run_sb(input int n, input int exp_bubbles);
        int bubbles = 0;
        logic [63:0] e;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            if (!if_valid) bubbles++;
            else begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_extra: got pc=%h instr=%h, expected nothing", if_pc, if_instr);
                end else begin
                    e = sb.pop_front();
                    if ({if_pc, if_instr} !== e) begin
                        fails++;
                        $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 if_pc, if_instr, e[63:32], e[31:0]);
                    end
                end
            end
        end
        tests++;
        if (bubbles !== exp_bubbles || sb.size() != 0) begin
            fails++;
            $display("FAIL sb_end: got bubbles=%0d left=%0d, expected bubbles=%0d left=0",
                     bubbles, sb.size(), exp_bubbles);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tests++;
        if ({if_valid, if_instr, if_pc, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_out: got v=%b instr=%h pc=%h addr=%h, expected 0/0/0/0",
                     if_valid, if_instr, if_pc, imem_addr);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests++;
        if (if_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_cycle0: got if_valid=%b, expected 0", if_valid);
        end
        push(0);
        run_sb(1, 0);
    endtask

    task automatic test_stream();
        do_reset();
`ifdef PREDECODE_BRANCH_EN
        for (int r = 0; r < 2; r++) for (int p = 0; p < 4; p++) push(p);
        run_sb(9, 1);
`else
        for (int p = 0; p < 6; p++) push(p);
        run_sb(6, 0);
`endif
    endtask

    task automatic test_stall();
        do_reset();
        push(0);
        run_sb(1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            tests++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd1, 32'h24400003}) begin
                fails++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h, expected 1/00000001/24400003",
                         i, if_valid, if_pc, if_instr);
            end
        end
        push(1); push(2); push(3);
        run_sb(3, 0);
    endtask

    task automatic test_redirect();
        do_reset();
        push(0);
        run_sb(1, 0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tests++;
        if ({if_valid, if_pc} !== {1'b1, 32'd1}) begin
            fails++;
            $display("FAIL redir_pre: got v=%b pc=%h, expected 1/00000001", if_valid, if_pc);
        end
        drive(1'b0, 1'b0, 1'b1, 32'd2);
        tests++;
        if (if_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_cycle: got if_valid=%b, expected 0", if_valid);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests++;
        if ({if_valid, imem_addr} !== {1'b0, 32'd2}) begin
            fails++;
            $display("FAIL redir_after: got v=%b addr=%h, expected 0/00000002", if_valid, imem_addr);
        end
        push(2); push(3);
        run_sb(2, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(0); push(1); push(2);
        run_sb(3, 0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tests++;
        if ({if_valid, if_pc} !== {1'b1, 32'd3}) begin
            fails++;
            $display("FAIL rstmid_hold: got v=%b pc=%h, expected 1/00000003", if_valid, if_pc);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests++;
        if ({if_valid, imem_addr} !== {1'b0, 32'd0}) begin
            fails++;
            $display("FAIL rstmid_after: got v=%b addr=%h, expected 0/00000000", if_valid, imem_addr);
        end
        push(0);
        run_sb(1, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
            tests++;
            if (if_valid !== 1'b0) begin
                fails++;
                $display("FAIL wrap_redir%0d: got if_valid=%b, expected 0", i, if_valid);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests++;
        if ({if_valid, imem_addr} !== {1'b0, 32'hFFFFFFFF}) begin
            fails++;
            $display("FAIL wrap_addr: got v=%b addr=%h, expected 0/ffffffff", if_valid, imem_addr);
        end
        push(32'hFFFFFFFF); push(0);
        run_sb(2, 0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
